// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle magnitude comparator. WIDTH-bit operands are compared DIGIT bits
// per clock, most significant digit first, behind a start/busy/done handshake.
// Signed compare is done by flipping the sign bit at capture, so that the
// scan itself is always unsigned.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   start            request a comparison; only honoured in IDLE
//   a, b             operands, captured on the accepted start
//   signed_mode      1 = two's-complement compare, captured with the operands
//   busy             high whenever the FSM is not IDLE
//   done             one-cycle pulse; gr/eq/le are valid from this cycle
//   gr, eq, le       A > B, A == B, A < B (one-hot, held until the next done)
module serial_magnitude_comparator #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIGIT      = 4,
    parameter int unsigned EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gr,
    output logic             eq,
    output logic             le
);

    localparam int unsigned NDIG  = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_width
        $error("serial_magnitude_comparator: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   a_sh_q,    a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,    b_sh_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               decided_q, decided_d;
    logic               res_gr_q,  res_gr_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               gr_q,      gr_d;
    logic               eq_q,      eq_d;
    logic               le_q,      le_d;

    // Current digit pair and the verdict it would give on its own
    logic [DIGIT-1:0]   dig_a, dig_b;
    logic               dig_ne, dig_gt;
    logic               fin_any, fin_gr;
    logic [WIDTH-1:0]   sign_mask;

    assign dig_a     = a_sh_q[WIDTH-1 -: DIGIT];
    assign dig_b     = b_sh_q[WIDTH-1 -: DIGIT];
    assign dig_ne    = (dig_a != dig_b);
    assign dig_gt    = (dig_a > dig_b);
    assign sign_mask = {signed_mode, (WIDTH-1)'(0)};

    // An earlier decided digit always wins over the current one
    assign fin_any   = decided_q | dig_ne;
    assign fin_gr    = decided_q ? res_gr_q : dig_gt;

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        res_gr_d  = res_gr_q;
        gr_d      = gr_q;
        eq_d      = eq_q;
        le_d      = le_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SCAN;
                    a_sh_d    = a ^ sign_mask;
                    b_sh_d    = b ^ sign_mask;
                    cnt_d     = '0;
                    decided_d = 1'b0;
                    res_gr_d  = 1'b0;
                end
            end
            SCAN: begin
                a_sh_d = a_sh_q << DIGIT;
                b_sh_d = b_sh_q << DIGIT;
                cnt_d  = cnt_q + CNT_W'(1);
                if (!decided_q && dig_ne) begin
                    decided_d = 1'b1;
                    res_gr_d  = dig_gt;
                end
                if (((EARLY_EXIT != 0) && dig_ne) || (cnt_q == LAST_DIG)) begin
                    state_d = DONE;
                    gr_d    = fin_any & fin_gr;
                    le_d    = fin_any & ~fin_gr;
                    eq_d    = ~fin_any;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            res_gr_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            gr_q      <= 1'b0;
            eq_q      <= 1'b1;
            le_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            res_gr_q  <= res_gr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            gr_q      <= gr_d;
            eq_q      <= eq_d;
            le_q      <= le_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gr   = gr_q;
    assign eq   = eq_q;
    assign le   = le_q;

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Parametrised, multi-cycle magnitude comparator that resolves `WIDTH`-bit operands `DIGIT` bits per clock, MSB-first, with selectable signed/unsigned interpretation and optional early termination. It extends the combinational 8-bit comparator to arbitrary widths at low area, behind a start/busy/done handshake. It sits in the datapath wherever wide comparisons can tolerate multi-cycle latency (sort/select units, limit checkers).

## Interface
- `WIDTH`, 32, operand width in bits; must be a multiple of `DIGIT`.
- `DIGIT`, 4, bits compared per cycle; `NDIG = WIDTH/DIGIT`.
- `EARLY_EXIT`, 1, 1 = finish on the first unequal digit; 0 = always scan `NDIG` digits (constant latency).
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request a comparison; sampled only in IDLE.
- `a` input WIDTH: operand A, captured on the accepted `start`.
- `b` input WIDTH: operand B, captured on the accepted `start`.
- `signed_mode` input 1: 1 = two's-complement compare; captured with operands.
- `busy` output 1: high while state is not IDLE.
- `done` output 1: one-cycle pulse; result valid.
- `gr` output 1: A > B.
- `eq` output 1: A == B.
- `le` output 1: A < B.

## Operation
- FSM states: IDLE, SCAN, DONE.
  - IDLE → SCAN on `start`. Captures `a`, `b` and `signed_mode` into shift registers, clears the digit counter and clears the internal `decided` flag.
  - SCAN compares the top `DIGIT` bits of both shift registers each cycle.
    - On the first unequal digit: latch `gr`/`le` from that digit, set `decided`.
    - Later digits never override a decided result.
    - Both registers shift left by `DIGIT`; the counter increments.
  - SCAN → DONE when (`EARLY_EXIT` and the current digit is unequal) or the counter reaches `NDIG-1`.
  - DONE → IDLE unconditionally after one cycle.
- Signed mode: the operand MSB (sign bit) of both operands is inverted at capture. The compare is then unsigned.
- `eq` = 1 only if no digit differed across the whole scan.
- Exactly one of `gr`/`eq`/`le` is high at all times.
- `gr`/`eq`/`le` are registered. They update only on the transition into DONE and hold until the next DONE or reset.
- `start` while `busy`=1 is ignored; the operands are not captured.

## Timing
- Reset values: `busy`=0, `done`=0, `gr`=0, `eq`=1, `le`=0. The FSM resets to IDLE and the counter to 0.
- Edge 0 is the accepted `start` edge. `busy` is high from edge 0.
- Digit j (0 = most significant) is compared in the cycle after edge j.
- Early exit on digit j: state is DONE after edge j+1; `done` and the result are high/valid for the cycle after edge j+1; IDLE after edge j+2.
- Full scan (equal operands, or `EARLY_EXIT`=0): DONE after edge `NDIG`, IDLE after edge `NDIG+1`.
- Back-to-back: `start` is accepted at the edge that leaves DONE? No. `start` is accepted only in IDLE, so the minimum issue interval is latency + 1 cycles.
- `NDIG`=1 is legal: SCAN lasts one cycle.
- Reset asserted mid-SCAN or in DONE:
  - All outputs go to their reset values immediately; the comparison is discarded.
  - No `done` pulse is issued after release.

## Test plan
- WIDTH=16, DIGIT=4, EARLY_EXIT=1, unsigned, `a`=0x1234, `b`=0x1234 → `eq`=1, `gr`=`le`=0; `done` in the cycle after edge 4.
- Same config, `a`=0x8000, `b`=0x7FFF:
  - unsigned → `gr`=1, `done` after edge 1;
  - `signed_mode`=1 → `le`=1, `done` after edge 1.
- Same config, `a`=0x1235, `b`=0x1234 → `gr`=1, `done` after edge 4. Then `a`=0xFFFF, `b`=0xFFFE signed → `gr`=1 (−1 > −2).
- EARLY_EXIT=0, `a`=0xF000, `b`=0x0F00 → `gr`=1 (decided on digit 0, not overridden by digit 1); `done` after edge 4.
- `start` pulsed with new operands while `busy`=1 → ignored; the in-flight result is unchanged; exactly one `done` pulse.
- `rst_n` low at the SCAN cycle after edge 2 → `busy`=0, `eq`=1, `gr`=`le`=0 immediately; no `done`; a fresh `start` after release completes normally.
